rate_detector: RTL and testbench
================================

# rate_detector

Receive-side counterpart of the rate divider. Watches a single-cycle enable pulse stream, measures the cycle interval between pulses and recovers the 2-bit Speed code that produced it (every cycle, 1 s, 2 s or 4 s at CLOCK_FREQUENCY). It also keeps a 4-bit pulse tally mirroring the display counter. It sits between a pulse source, such as an external board link or the divider under self-test, and the hex display or LEDs.

## Interface
- CLOCK_FREQUENCY, 50000000: cycles per second. Must be ≥ 2 so the four interval classes are distinct.
- ClockIn  in  1  sole clock; all logic on posedge.
- Reset  in  1  synchronous, active-high; one clock; reset is synchronous and active-high.
- Pulse  in  1  enable pulse being measured; sampled each posedge.
- Speed  out  2  last locked speed code.
- Locked  out  1  high while the pulse stream matches Speed.
- Error  out  1  one-cycle strobe on invalid interval, class change while locked, or timeout.
- PulseCount  out  4  pulses seen since reset, modulo 16.

## Operation
- Interval counter width is $clog2(4*CLOCK_FREQUENCY+1).
  - A Pulse cycle loads 1.
  - Otherwise it increments in states FIRST, CAND and LOCKED; it holds 0 in IDLE.
- At a Pulse cycle, the measured period P is the current Interval value, i.e. cycles since the previous pulse.
- Classification of P:
  - 1 → 00
  - CF → 01
  - 2·CF → 10
  - 4·CF → 11
  - anything else → invalid
- States IDLE, FIRST, CAND, LOCKED; a Cand register holds 2 bits.
- IDLE: on Pulse → FIRST. No classification happens, because there is no prior reference.
- FIRST, on Pulse:
  - valid: Cand ← class, go to CAND.
  - invalid: Error, stay in FIRST.
- CAND, on Pulse:
  - valid and equal to Cand: Speed ← class, Locked ← 1, go to LOCKED.
  - valid and different: Cand ← class, stay in CAND, no Error.
  - invalid: Error, go to FIRST.
- LOCKED, on Pulse:
  - class equals Speed: stay.
  - valid and different: Error, Locked ← 0, Cand ← class, go to CAND.
  - invalid: Error, Locked ← 0, go to FIRST.
- Timeout: in FIRST, CAND or LOCKED, if Interval == 4·CF and Pulse = 0:
  - Error, Locked ← 0, go to IDLE, Interval ← 0.
  - A pulse at exactly Interval == 4·CF is valid and is not a timeout.
- Speed changes only on entry to LOCKED and holds through errors, timeouts and unlock.
- PulseCount increments on every non-reset Pulse cycle in every state and wraps 15 → 0.

## Timing
- All outputs are registered. Effects of a Pulse sampled at edge N are visible after edge N. Error is high for exactly one cycle.
- Lock latency is 3 pulses from IDLE: the first pulse arms, the second sets Cand, and the third confirms. Locked rises in the cycle after the third pulse.
- Timeout: with the last pulse at cycle t, Interval = 4·CF at cycle t+4·CF. Error and Locked = 0 appear at t+4·CF+1.
- Reset state after the edge where Reset is sampled high:
  - state IDLE, Interval 0, Cand 00
  - Speed 00, Locked 0, Error 0, PulseCount 0
- Reset overrides a simultaneous Pulse: the pulse is neither counted nor classified.
- Reset mid-lock or mid-measurement discards all history.
- No combinational path from Pulse to any output.

## Test plan
Benches use CLOCK_FREQUENCY = 4.
- Reset, then Pulse high for 3 consecutive cycles:
  - Locked = 1 and Speed = 00 one cycle after the third pulse.
  - PulseCount = 3, Error never high.
- Pulses every 8 cycles, ×3:
  - Locked = 1, Speed = 10 after the third pulse, no Error.
- Locked at 01 (period 4), then next pulse at period 5:
  - Error for 1 cycle, Locked = 0, Speed stays 01.
  - Two further period-4 pulses: Locked = 1, Speed = 01.
- Locked at 11 (period 16), last pulse at cycle t, Pulse held low:
  - Error high only at t+17, Locked = 0 from t+17.
  - The next single pulse does not lock.
- Locked at 00, then period-8 pulses:
  - First one gives Error, Locked = 0, state CAND.
  - Second one gives Locked = 1, Speed = 10.
- 17 back-to-back pulses give PulseCount = 1.
- Then Reset and Pulse together while locked: next cycle all outputs 0 and PulseCount stays 0.

Source files
------------

// File: rtl/rate_detector.sv
// Recovers the 2-bit speed code of a single-cycle enable pulse stream by
// measuring the interval between pulses, and tallies pulses modulo 16.
module rate_detector #(
  parameter int CLOCK_FREQUENCY = 50000000
) (
  input  logic       ClockIn,
  input  logic       Reset,
  input  logic       Pulse,
  output logic [1:0] Speed,
  output logic       Locked,
  output logic       Error,
  output logic [3:0] PulseCount
);

  localparam int IW = $clog2(4 * CLOCK_FREQUENCY + 1);
  localparam logic [IW-1:0] INTERVAL_MAX = IW'(4 * CLOCK_FREQUENCY);
  localparam logic [IW-1:0] INTERVAL_ONE = IW'(1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_FIRST,
    S_CAND,
    S_LOCKED
  } state_t;

  state_t        r_state;
  logic [IW-1:0] r_interval;
  logic [1:0]    r_cand;
  logic [1:0]    r_speed;
  logic          r_locked;
  logic          r_error;
  logic [3:0]    r_pulse_count;

  logic [3:0]    w_match;
  logic          w_valid;
  logic [1:0]    w_class;
  logic          w_at_max;

  // Class gi corresponds to a period of 1, CF, 2*CF or 4*CF cycles.
  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_class
      localparam int PERIOD = (gi == 0) ? 1 :
                              (gi == 1) ? CLOCK_FREQUENCY :
                              (gi == 2) ? 2 * CLOCK_FREQUENCY :
                                          4 * CLOCK_FREQUENCY;
      assign w_match[gi] = (r_interval == IW'(PERIOD));
    end
  endgenerate

  assign w_valid  = |w_match;
  assign w_at_max = (r_interval == INTERVAL_MAX);

  always_comb begin
    w_class = 2'd0;
    if (w_match[3])      w_class = 2'd3;
    else if (w_match[2]) w_class = 2'd2;
    else if (w_match[1]) w_class = 2'd1;
  end

  always_ff @(posedge ClockIn) begin
    if (Reset) begin
      r_state       <= S_IDLE;
      r_interval    <= '0;
      r_cand        <= 2'd0;
      r_speed       <= 2'd0;
      r_locked      <= 1'b0;
      r_error       <= 1'b0;
      r_pulse_count <= 4'd0;
    end else begin
      r_error <= 1'b0;
      if (Pulse) r_pulse_count <= r_pulse_count + 4'd1;

      if (r_state == S_IDLE) begin
        // First pulse only arms the measurement; there is no prior reference.
        if (Pulse) begin
          r_state    <= S_FIRST;
          r_interval <= INTERVAL_ONE;
        end else begin
          r_interval <= '0;
        end
      end else if (Pulse) begin
        r_interval <= INTERVAL_ONE;
        case (r_state)
          S_FIRST: begin
            if (w_valid) begin
              r_cand  <= w_class;
              r_state <= S_CAND;
            end else begin
              r_error <= 1'b1;
            end
          end
          S_CAND: begin
            if (w_valid && (w_class == r_cand)) begin
              r_speed  <= w_class;
              r_locked <= 1'b1;
              r_state  <= S_LOCKED;
            end else if (w_valid) begin
              r_cand <= w_class;
            end else begin
              r_error <= 1'b1;
              r_state <= S_FIRST;
            end
          end
          S_LOCKED: begin
            if (w_valid && (w_class == r_speed)) begin
              r_state <= S_LOCKED;
            end else if (w_valid) begin
              r_error  <= 1'b1;
              r_locked <= 1'b0;
              r_cand   <= w_class;
              r_state  <= S_CAND;
            end else begin
              r_error  <= 1'b1;
              r_locked <= 1'b0;
              r_state  <= S_FIRST;
            end
          end
          default: r_state <= S_IDLE;
        endcase
      end else if (w_at_max) begin
        // Longest legal period elapsed with no pulse: drop back and rearm.
        r_error    <= 1'b1;
        r_locked   <= 1'b0;
        r_state    <= S_IDLE;
        r_interval <= '0;
      end else begin
        r_interval <= r_interval + INTERVAL_ONE;
      end
    end
  end

  assign Speed      = r_speed;
  assign Locked     = r_locked;
  assign Error      = r_error;
  assign PulseCount = r_pulse_count;

endmodule

// File: tb/tb_rate_detector.sv
// Directed bench for rate_detector at CLOCK_FREQUENCY = 4: vector table plus
// hand-written timeout, wrap and reset-override sequences.
module tb_rate_detector;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       pul = 1'b0;
  logic [1:0] speed;
  logic       locked;
  logic       err;
  logic [3:0] cnt;

  int checks = 0;
  int errors = 0;

  rate_detector #(.CLOCK_FREQUENCY(4)) dut (
    .ClockIn   (clk),
    .Reset     (rst),
    .Pulse     (pul),
    .Speed     (speed),
    .Locked    (locked),
    .Error     (err),
    .PulseCount(cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       rst;
    int         gap;
    logic       pul;
    logic [1:0] speed;
    logic       locked;
    logic       err;
    logic [3:0] cnt;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic r, input int g, input logic p, input logic [1:0] s,
                     input logic l, input logic e, input logic [3:0] c);
    vec_t v;
    v.rst = r; v.gap = g; v.pul = p; v.speed = s; v.locked = l; v.err = e; v.cnt = c;
    vecs.push_back(v);
  endtask

  task automatic step(input logic r, input logic p);
    rst = r;
    pul = p;
    @(posedge clk);
    #1;
    rst = 1'b0;
    pul = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0);
  endtask

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic chk_all(input string tag, input int s, input int l, input int e, input int c);
    chk({tag, " speed"}, int'(speed), s);
    chk({tag, " locked"}, int'(locked), l);
    chk({tag, " error"}, int'(err), e);
    chk({tag, " count"}, int'(cnt), c);
  endtask

  initial begin
    // rst gap pul | speed locked err cnt
    add(1, 0, 0, 0, 0, 0, 0);  // reset state
    add(0, 0, 1, 0, 0, 0, 1);  // arm
    add(0, 0, 1, 0, 0, 0, 2);  // cand 00
    add(0, 0, 1, 0, 1, 0, 3);  // lock 00
    add(0, 7, 1, 0, 0, 1, 4);  // period 8 while locked 00 -> CAND
    add(0, 7, 1, 2, 1, 0, 5);  // second period 8 -> lock 10
    add(0, 0, 0, 2, 1, 0, 5);  // idle, no pulse
    add(0, 6, 1, 2, 1, 0, 6);  // period 8 keeps lock
    add(1, 0, 0, 0, 0, 0, 0);  // reset
    add(0, 0, 1, 0, 0, 0, 1);  // arm
    add(0, 7, 1, 0, 0, 0, 2);  // period 8 -> cand 10
    add(0, 7, 1, 2, 1, 0, 3);  // lock 10
    add(0, 3, 1, 2, 0, 1, 4);  // period 4 differs -> CAND 01
    add(0, 0, 0, 2, 0, 0, 4);  // error lasts one cycle
    add(0, 2, 1, 1, 1, 0, 5);  // period 4 -> lock 01
    add(0, 4, 1, 1, 0, 1, 6);  // period 5 invalid -> FIRST
    add(0, 0, 0, 1, 0, 0, 6);  // error cleared, speed held
    add(0, 2, 1, 1, 0, 0, 7);  // period 4 -> CAND
    add(0, 3, 1, 1, 1, 0, 8);  // period 4 -> relock 01

    for (int i = 0; i < vecs.size(); i++) begin
      idle(vecs[i].gap);
      step(vecs[i].rst, vecs[i].pul);
      $display("vec %0d: rst=%0b gap=%0d pulse=%0b -> speed=%0d locked=%0b error=%0b count=%0d",
               i, vecs[i].rst, vecs[i].gap, vecs[i].pul, speed, locked, err, cnt);
      chk($sformatf("vec%0d", i), {30'd0, speed}, {30'd0, vecs[i].speed});
      chk($sformatf("vec%0d locked", i), int'(locked), int'(vecs[i].locked));
      chk($sformatf("vec%0d error", i), int'(err), int'(vecs[i].err));
      chk($sformatf("vec%0d count", i), int'(cnt), int'(vecs[i].cnt));
    end

    // Lock at period 16 (pulse exactly at 4*CF is valid), then time out.
    step(1'b1, 1'b0);
    step(1'b0, 1'b1);
    idle(15);
    step(1'b0, 1'b1);
    chk_all("p16 cand", 0, 0, 0, 2);
    idle(15);
    step(1'b0, 1'b1);
    $display("timeout: locked at period 16 speed=%0d locked=%0b", speed, locked);
    chk_all("p16 lock", 3, 1, 0, 3);
    for (int k = 1; k <= 17; k++) begin
      step(1'b0, 1'b0);
      $display("timeout: idle cycle %0d error=%0b locked=%0b", k, err, locked);
      chk($sformatf("timeout k%0d error", k), int'(err), (k == 16) ? 1 : 0);
      chk($sformatf("timeout k%0d locked", k), int'(locked), (k < 16) ? 1 : 0);
    end
    chk("timeout speed held", int'(speed), 3);
    step(1'b0, 1'b1);
    $display("timeout: single pulse afterwards locked=%0b error=%0b", locked, err);
    chk_all("post-timeout pulse", 3, 0, 0, 4);

    // 17 back-to-back pulses wrap the tally to 1.
    step(1'b1, 1'b0);
    for (int i = 0; i < 17; i++) step(1'b0, 1'b1);
    $display("wrap: 17 pulses count=%0d locked=%0b speed=%0d", cnt, locked, speed);
    chk_all("wrap", 0, 1, 0, 1);

    // Reset wins over a simultaneous pulse while locked.
    step(1'b1, 1'b1);
    $display("reset+pulse: speed=%0d locked=%0b error=%0b count=%0d", speed, locked, err, cnt);
    chk_all("reset+pulse", 0, 0, 0, 0);
    step(1'b0, 1'b1);
    $display("after reset: one pulse count=%0d locked=%0b", cnt, locked);
    chk_all("after reset pulse", 0, 0, 0, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
